// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - mdu opcodes, state encoding and op decode helpers; MDU_DIV_EN enables the divider
package mdu_pkg;

  localparam logic [2:0] mdu_mul    = 3'd0;
  localparam logic [2:0] mdu_mulh   = 3'd1;
  localparam logic [2:0] mdu_mulhsu = 3'd2;
  localparam logic [2:0] mdu_mulhu  = 3'd3;
  localparam logic [2:0] mdu_div    = 3'd4;
  localparam logic [2:0] mdu_divu   = 3'd5;
  localparam logic [2:0] mdu_rem    = 3'd6;
  localparam logic [2:0] mdu_remu   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Divider is left out unless the build defines MDU_DIV_EN.
`ifdef MDU_DIV_EN
  localparam bit mdu_div_en = 1'b1;
`else
  localparam bit mdu_div_en = 1'b0;
`endif

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_src1_signed(input logic [2:0] op);
    return (op == mdu_mul) || (op == mdu_mulh) || (op == mdu_mulhsu) ||
           (op == mdu_div) || (op == mdu_rem);
  endfunction

  function automatic logic op_src2_signed(input logic [2:0] op);
    return (op == mdu_mul) || (op == mdu_mulh) || (op == mdu_div) || (op == mdu_rem);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_bit_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // shift in the next dividend bit and subtract the divisor when it fits
  always_comb begin
    shifted   = {rem_i, dividend_bit_i};
    // when the subtraction is taken the true difference is below the divisor, so XLEN bits suffice
    diff      = shifted[XLEN-1:0] - divisor_i;
    quo_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o     = quo_bit_o ? diff : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative RV32M multiply/divide unit; divider present only with MDU_DIV_EN
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] mdu_src1_i,
  input  logic [XLEN-1:0] mdu_src2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] mdu_result_o
);

  mdu_state_e        state_q;
  logic [2:0]        op_q;
  logic              sign1_q, sign2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   acc_hi_q, acc_lo_q, opb_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  logic              neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              spec_hit;
  logic [XLEN-1:0]   spec_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   hi_nxt, lo_nxt, res_fin;
  logic [2*XLEN-1:0] prod;

  assign ready_o      = (state_q == IDLE);
  assign valid_o      = valid_q;
  assign mdu_result_o = result_q;

  // operand magnitudes, sign flags and special-case decode for the incoming request
  always_comb begin
    neg1     = op_src1_signed(mdu_op_i) & mdu_src1_i[XLEN-1];
    neg2     = op_src2_signed(mdu_op_i) & mdu_src2_i[XLEN-1];
    mag1     = neg1 ? -mdu_src1_i : mdu_src1_i;
    mag2     = neg2 ? -mdu_src2_i : mdu_src2_i;
    spec_hit = 1'b0;
    spec_res = '0;
`ifdef MDU_DIV_EN
    if (is_div_op(mdu_op_i)) begin
      if (mdu_src2_i == '0) begin
        spec_hit = 1'b1;
        spec_res = mdu_op_i[1] ? mdu_src1_i : '1;
      end else if (op_src1_signed(mdu_op_i) && (mdu_src1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (mdu_src2_i == '1)) begin
        spec_hit = 1'b1;
        spec_res = mdu_op_i[1] ? '0 : mdu_src1_i;
      end
    end
`else
    // without a divider every divide op finishes at once with a zero result
    spec_hit = is_div_op(mdu_op_i);
`endif
  end

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] div_rem;
  logic            div_qbit;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i          (acc_hi_q),
    .dividend_bit_i (acc_lo_q[XLEN-1]),
    .divisor_i      (opb_q),
    .rem_o          (div_rem),
    .quo_bit_o      (div_qbit)
  );
`endif

  // one iteration of the accumulators and the signed result if it is the last one
  always_comb begin
    // acc_hi:acc_lo is the running product; acc_lo shifts the multiplier out as product bits shift in
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    hi_nxt  = mul_sum[XLEN:1];
    lo_nxt  = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    prod    = {hi_nxt, lo_nxt};
    if (sign1_q ^ sign2_q) prod = -prod;
    res_fin = (op_q == mdu_mul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    // divide reuses acc_hi as partial remainder and acc_lo as dividend/quotient shift register
    if (is_div_op(op_q)) begin
      hi_nxt = div_rem;
      lo_nxt = {acc_lo_q[XLEN-2:0], div_qbit};
      if (op_q[1]) res_fin = sign1_q ? -hi_nxt : hi_nxt;
      else         res_fin = (sign1_q ^ sign2_q) ? -lo_nxt : lo_nxt;
    end
`endif
  end

  // control FSM with registered result and valid; flush overrides everything
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q     <= mdu_op_i;
            sign1_q  <= neg1;
            sign2_q  <= neg2;
            cnt_q    <= CNT_W'(XLEN-1);
            acc_hi_q <= '0;
            acc_lo_q <= is_div_op(mdu_op_i) ? mag1 : mag2;
            opb_q    <= is_div_op(mdu_op_i) ? mag2 : mag1;
            if (spec_hit) begin
              result_q <= spec_res;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          acc_hi_q <= hi_nxt;
          acc_lo_q <= lo_nxt;
          if (cnt_q == '0) begin
            result_q <= res_fin;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - table-driven self-checking bench for mdu
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [2:0]  op = 3'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mdu #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .valid_i      (valid_in),
    .ready_o      (ready_out),
    .mdu_op_i     (op),
    .mdu_src1_i   (src1),
    .mdu_src2_i   (src2),
    .valid_o      (valid_out),
    .ready_i      (ready_in),
    .mdu_result_o (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] e, input bit s, input string n);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.special = s; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // issue one request, wait for the result, optionally backpressure, then consume it
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold, input string name);
    int k;
    bit busy_bad;
    @(negedge clk);
    check({name, " ready_idle"}, 32'(ready_out), 32'd1);
    valid_in = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    valid_in = 1'b0;
    k = 0;
    busy_bad = 1'b0;
    while (!valid_out && k < 200) begin
      if (ready_out) busy_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(lat));
    check({name, " ready_low"}, 32'(ready_out | busy_bad), 32'd0);
    check({name, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s hold%0d result", name, i), result, exp);
      check($sformatf("%s hold%0d valid", name, i), 32'(valid_out), 32'd1);
      check($sformatf("%s hold%0d ready", name, i), 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check({name, " release_valid"}, 32'(valid_out), 32'd0);
    check({name, " release_ready"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    int lat;
    bit seen;
    logic [2:0] fop;

    vecs.push_back(mkv(mdu_mul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3"));
    vecs.push_back(mkv(mdu_mul,    32'h12345678, 32'h10,       32'h23456780, 1'b0, "mul_shift"));
    vecs.push_back(mkv(mdu_mulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_ones"));
    vecs.push_back(mkv(mdu_mulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh_ones"));
    vecs.push_back(mkv(mdu_mulhsu, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, "mulhsu_m1_2"));
    vecs.push_back(mkv(mdu_mulhsu, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "mulhsu_min"));
    vecs.push_back(mkv(mdu_mulhu,  32'h12345678, 32'h10,       32'h00000001, 1'b0, "mulhu_small"));
    vecs.push_back(mkv(mdu_div,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2"));
    vecs.push_back(mkv(mdu_rem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "rem_m7_2"));
    vecs.push_back(mkv(mdu_div,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2"));
    vecs.push_back(mkv(mdu_rem,    32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, "rem_7_m2"));
    vecs.push_back(mkv(mdu_divu,   32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7"));
    vecs.push_back(mkv(mdu_remu,   32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7"));
    vecs.push_back(mkv(mdu_divu,   32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0, "divu_big"));
    vecs.push_back(mkv(mdu_remu,   32'hFFFFFFFF, 32'h10,       32'h0000000F, 1'b0, "remu_big"));
    vecs.push_back(mkv(mdu_div,    32'h80000000, 32'd1,        32'h80000000, 1'b0, "div_min_1"));
    vecs.push_back(mkv(mdu_divu,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0"));
    vecs.push_back(mkv(mdu_div,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "div_by0"));
    vecs.push_back(mkv(mdu_rem,    32'd5,        32'd0,        32'd5,        1'b1, "rem_by0"));
    vecs.push_back(mkv(mdu_remu,   32'd5,        32'd0,        32'd5,        1'b1, "remu_by0"));
    vecs.push_back(mkv(mdu_div,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf"));
    vecs.push_back(mkv(mdu_rem,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf"));

    #12;
    check("reset ready", 32'(ready_out), 32'd1);
    check("reset valid", 32'(valid_out), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      e   = vecs[i].exp;
      lat = vecs[i].special ? 0 : 32;
      if (vecs[i].op[2] && !mdu_div_en) begin
        e   = 32'd0;
        lat = 0;
      end
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, e, lat, 0, vecs[i].name);
    end

    do_op(mdu_mul, 32'd6, 32'd7, 32'd42, 32, 5, "backpressure");

    fop = mdu_div_en ? mdu_divu : mdu_mul;
    @(negedge clk);
    valid_in = 1'b1; op = fop; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_calc busy", 32'(ready_out), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc ready", 32'(ready_out), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      if (valid_out) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_calc no_valid", 32'(seen), 32'd0);

    flush = 1'b1; valid_in = 1'b1; op = mdu_mul; src1 = 32'd3; src2 = 32'd3;
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0;
    check("flush_accept ready", 32'(ready_out), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      if (valid_out || !ready_out) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_accept idle", 32'(seen), 32'd0);
    check("flush_accept result", result, 32'd42);

    valid_in = 1'b1; op = mdu_mul; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid busy", 32'(ready_out), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid ready", 32'(ready_out), 32'd1);
    check("rst_mid valid", 32'(valid_out), 32'd0);
    check("rst_mid result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(mdu_mul, 32'd3, 32'd5, 32'd15, 32, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
